// File: rtl/div_arbiter_pkg.sv
// div_arb_pkg: shared constants and the tag record that follows every
// division through the shared divider pipeline.
//   DIV_LATENCY_DEFAULT : default divider latency (input to quotient)
//   INFLIGHT_W          : width of each per-requester in-flight counter
//   TAG_ID_W            : owner-id width, sized for the largest supported
//                         requester count so one tag type serves every build
//   div_tag_t           : {valid, id, dz, ovf} carried beside each operation
package div_arb_pkg;

    localparam int DIV_LATENCY_DEFAULT = 11;
    localparam int INFLIGHT_W          = 5;
    localparam int NUM_REQ_MAX         = 16;
    localparam int TAG_ID_W            = $clog2(NUM_REQ_MAX);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                dz;
        logic                ovf;
    } div_tag_t;

endpackage

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: request, divider and response signals of the divider
// arbiter bundled into one interface.
//   slave  modport : arbiter view (takes requests, drives divider operands,
//                    returns responses and in-flight counts)
//   master modport : lanes + divider view (drives requests and div_result)
//   req_valid/req_ready : per-requester handshake, req_ready one-hot
//   req_a/req_b         : packed operands, requester i at [i*DATA_LEN +: DATA_LEN]
//   div_a/div_b         : registered operands to the divider
//   div_result          : quotient from the divider
//   rsp_valid/rsp_result/rsp_dz/rsp_ovf : one-cycle response strobe and data
//   inflight            : packed per-requester outstanding-operation counts
interface div_arbiter_if #(
    parameter int DATA_LEN = 32,
    parameter int NUM_REQ  = 4
);
    import div_arb_pkg::*;

    logic        [NUM_REQ-1:0]            req_valid;
    logic        [NUM_REQ-1:0]            req_ready;
    logic        [NUM_REQ*DATA_LEN-1:0]   req_a;
    logic        [NUM_REQ*DATA_LEN-1:0]   req_b;
    logic signed [DATA_LEN-1:0]           div_a;
    logic signed [DATA_LEN-1:0]           div_b;
    logic signed [DATA_LEN-1:0]           div_result;
    logic        [NUM_REQ-1:0]            rsp_valid;
    logic signed [DATA_LEN-1:0]           rsp_result;
    logic                                 rsp_dz;
    logic                                 rsp_ovf;
    logic        [NUM_REQ*INFLIGHT_W-1:0] inflight;

    modport slave (
        input  req_valid, req_a, req_b, div_result,
        output req_ready, div_a, div_b, rsp_valid, rsp_result, rsp_dz, rsp_ovf,
               inflight
    );

    modport master (
        output req_valid, req_a, req_b, div_result,
        input  req_ready, div_a, div_b, rsp_valid, rsp_result, rsp_dz, rsp_ovf,
               inflight
    );

endinterface

// File: rtl/div_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant generator with its own pointer.
//   clk, reset : clock, asynchronous active-low reset
//   req        : request vector
//   advance    : a grant was accepted this cycle; move the pointer past it
//   grant      : one-hot grant, first request at or above the pointer (wrapping)
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             found;

    // (base + off) mod N, for off < N; N need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return PTR_W'(sum);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[wrap_add(rr_ptr, i)]) begin
                found                        = 1'b1;
                grant_idx                    = wrap_add(rr_ptr, i);
                grant[wrap_add(rr_ptr, i)]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (advance && found) begin
            rr_ptr <= wrap_add(grant_idx, 1);
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one pipelined signed divider among NUM_REQ requesters.
// Accepts one division per cycle in round-robin order, registers the operands
// into the divider, carries an owner tag beside each operation and returns the
// quotient to its originator with divide-by-zero / overflow flags.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : div_arbiter_if.slave (requests, divider operands/result,
//           responses, per-requester in-flight counts)
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int DATA_LEN    = 32,
    parameter int NUM_REQ     = 4,
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    div_arbiter_if.slave  bus
);

    localparam logic signed [DATA_LEN-1:0] INT_MIN = {1'b1, {(DATA_LEN-1){1'b0}}};

    function automatic logic is_dz(input logic signed [DATA_LEN-1:0] b);
        return (b == '0);
    endfunction

    function automatic logic is_ovf(input logic signed [DATA_LEN-1:0] a,
                                    input logic signed [DATA_LEN-1:0] b);
        return (a == INT_MIN) && (b == '1);
    endfunction

    // The divider output is meaningless for flagged operations, so the
    // quotient is substituted rather than passed through.
    function automatic logic signed [DATA_LEN-1:0] resolve_quotient(
        input div_tag_t tag, input logic signed [DATA_LEN-1:0] q);
        if (tag.dz)  return '0;
        if (tag.ovf) return INT_MIN;
        return q;
    endfunction

    function automatic logic [INFLIGHT_W-1:0] sat_count(
        input logic [INFLIGHT_W-1:0] cnt, input logic inc, input logic dec);
        if (inc && !dec && cnt != '1) return cnt + 1'b1;
        if (dec && !inc && cnt != '0) return cnt - 1'b1;
        return cnt;
    endfunction

    logic        [NUM_REQ-1:0]            grant;
    logic        [NUM_REQ-1:0]            hs_vec;
    logic                                 hs;
    logic signed [DATA_LEN-1:0]           sel_a;
    logic signed [DATA_LEN-1:0]           sel_b;
    logic        [TAG_ID_W-1:0]           sel_id;
    logic signed [DATA_LEN-1:0]           div_a_p0;
    logic signed [DATA_LEN-1:0]           div_b_p0;
    div_tag_t                             tag_pipe [DIV_LATENCY+1];
    div_tag_t                             tag_last;
    logic        [NUM_REQ-1:0]            dec_vec;
    logic        [NUM_REQ-1:0]            rsp_vld_p1;
    logic signed [DATA_LEN-1:0]           rsp_result_p1;
    logic                                 rsp_dz_p1;
    logic                                 rsp_ovf_p1;
    logic        [INFLIGHT_W-1:0]         inflight_cnt [NUM_REQ];
    logic        [NUM_REQ*INFLIGHT_W-1:0] inflight_flat;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req_valid),
        .advance (hs),
        .grant   (grant)
    );

    assign bus.req_ready = grant;
    assign hs_vec        = bus.req_valid & grant;
    assign hs            = |hs_vec;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a  = bus.req_a[i*DATA_LEN +: DATA_LEN];
                sel_b  = bus.req_b[i*DATA_LEN +: DATA_LEN];
                sel_id = TAG_ID_W'(i);
            end
        end
    end

    // ---- stage p0: issue register and tag pipeline (tag_pipe[0] = p0) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_a_p0 <= '0;
            div_b_p0 <= '0;
            for (int k = 0; k <= DIV_LATENCY; k++) tag_pipe[k] <= '0;
        end else begin
            if (hs) begin
                div_a_p0 <= sel_a;
                div_b_p0 <= sel_b;
            end
            tag_pipe[0] <= '{valid: hs, id: sel_id,
                              dz: is_dz(sel_b), ovf: is_ovf(sel_a, sel_b)};
            for (int k = 1; k <= DIV_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign bus.div_a = div_a_p0;
    assign bus.div_b = div_b_p0;
    assign tag_last  = tag_pipe[DIV_LATENCY];

    always_comb begin
        dec_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dec_vec[i] = tag_last.valid && (tag_last.id == TAG_ID_W'(i));
        end
    end

    // ---- stage p1: response register, aligned with the divider output ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_vld_p1    <= '0;
            rsp_result_p1 <= '0;
            rsp_dz_p1     <= 1'b0;
            rsp_ovf_p1    <= 1'b0;
        end else begin
            rsp_vld_p1    <= dec_vec;
            rsp_result_p1 <= tag_last.valid ? resolve_quotient(tag_last, bus.div_result) : '0;
            rsp_dz_p1     <= tag_last.valid && tag_last.dz;
            rsp_ovf_p1    <= tag_last.valid && tag_last.ovf;
        end
    end

    assign bus.rsp_valid  = rsp_vld_p1;
    assign bus.rsp_result = rsp_result_p1;
    assign bus.rsp_dz     = rsp_dz_p1;
    assign bus.rsp_ovf    = rsp_ovf_p1;

    // An operation stops counting on the edge its response strobe is raised.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) inflight_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                inflight_cnt[i] <= sat_count(inflight_cnt[i], hs_vec[i], dec_vec[i]);
            end
        end
    end

    always_comb begin
        inflight_flat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            inflight_flat[i*INFLIGHT_W +: INFLIGHT_W] = inflight_cnt[i];
        end
    end

    assign bus.inflight = inflight_flat;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: self-checking bench for div_arbiter with a behavioural
// 11-cycle divider, a table of single-operation vectors and hand-written
// multi-cycle sequences; all responses are also matched against a queue.
module tb_div_arbiter;
    import div_arb_pkg::*;

    localparam int DATA_LEN    = 32;
    localparam int NUM_REQ     = 4;
    localparam int DIV_LATENCY = 11;
    localparam int RSP_LAT     = DIV_LATENCY + 1;
    localparam logic signed [31:0] INT_MIN = 32'sh80000000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_arbiter_if #(.DATA_LEN(DATA_LEN), .NUM_REQ(NUM_REQ)) bus ();

    div_arbiter #(.DATA_LEN(DATA_LEN), .NUM_REQ(NUM_REQ), .DIV_LATENCY(DIV_LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural divider: 11 registers, junk on undefined cases so the
    // arbiter must substitute its own results there.
    function automatic logic signed [31:0] div_model(input logic signed [31:0] a,
                                                     input logic signed [31:0] b);
        if (b == 0 || (a == INT_MIN && b == -1)) return 32'sh5A5A5A5A;
        return a / b;
    endfunction

    logic signed [31:0] dpipe [DIV_LATENCY];
    always @(posedge clk) begin
        dpipe[0] <= div_model(bus.div_a, bus.div_b);
        for (int k = 1; k < DIV_LATENCY; k++) dpipe[k] <= dpipe[k-1];
    end
    assign bus.div_result = dpipe[DIV_LATENCY-1];

    typedef struct {
        int                 id;
        logic signed [31:0] q;
        bit                 dz;
        bit                 ovf;
        int                 due;
    } exp_t;

    exp_t sbq[$];

    function automatic exp_t ref_model(input int id, input logic signed [31:0] a,
                                       input logic signed [31:0] b, input int due);
        exp_t e;
        e.id  = id;
        e.dz  = (b == 0);
        e.ovf = (a == INT_MIN) && (b == -1);
        e.q   = e.dz ? 32'sd0 : (e.ovf ? INT_MIN : a / b);
        e.due = due;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: push on each handshake seen, pop on each response strobe.
    logic [NUM_REQ-1:0] mon_hs;
    exp_t               mon_e;
    always @(negedge clk) begin
        if (reset) begin
            mon_hs = bus.req_valid & bus.req_ready;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (mon_hs[i])
                    sbq.push_back(ref_model(i, bus.req_a[i*DATA_LEN +: DATA_LEN],
                                            bus.req_b[i*DATA_LEN +: DATA_LEN], cyc + RSP_LAT + 1));
            end
            if (bus.rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding (cycle %0d)",
                             bus.rsp_valid, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check("sb_rsp_id", 32'(bus.rsp_valid), 32'(1) << mon_e.id);
                    check("sb_rsp_result", bus.rsp_result, mon_e.q);
                    check("sb_rsp_dz", 32'(bus.rsp_dz), 32'(mon_e.dz));
                    check("sb_rsp_ovf", 32'(bus.rsp_ovf), 32'(mon_e.ovf));
                    check("sb_rsp_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic signed [31:0] a, input logic signed [31:0] b);
        bus.req_valid[id]                     = 1'b1;
        bus.req_a[id*DATA_LEN +: DATA_LEN]    = a;
        bus.req_b[id*DATA_LEN +: DATA_LEN]    = b;
    endtask

    function automatic logic [31:0] get_inflight(input int id);
        return 32'(bus.inflight[id*INFLIGHT_W +: INFLIGHT_W]);
    endfunction

    task automatic wait_drain();
        for (int t = 0; t < 200 && sbq.size() != 0; t++) tick();
        check("drain", sbq.size(), 0);
    endtask

    typedef struct {
        int                 id;
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic signed [31:0] q;
        bit                 dz;
        bit                 ovf;
    } vec_t;

    task automatic apply_one(input vec_t v);
        int n;
        set_req(v.id, v.a, v.b);
        #1;
        check("grant", 32'(bus.req_ready), 32'(1) << v.id);
        tick();
        bus.req_valid = '0;
        check("div_a", bus.div_a, v.a);
        check("div_b", bus.div_b, v.b);
        check("inflight_up", get_inflight(v.id), 1);
        n = 0;
        while (bus.rsp_valid == '0 && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, RSP_LAT);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << v.id);
        check("rsp_result", bus.rsp_result, v.q);
        check("rsp_dz", 32'(bus.rsp_dz), 32'(v.dz));
        check("rsp_ovf", 32'(bus.rsp_ovf), 32'(v.ovf));
        check("inflight_down", get_inflight(v.id), 0);
        tick();
        check("rsp_pulse", 32'(bus.rsp_valid), 0);
    endtask

    vec_t vt [8];
    vec_t fresh;

    initial begin
        vt[0] = '{0, 100, 7, 14, 0, 0};
        vt[1] = '{1, -7, 2, -3, 0, 0};
        vt[2] = '{2, 5, 0, 0, 1, 0};
        vt[3] = '{3, INT_MIN, -1, INT_MIN, 0, 1};
        vt[4] = '{0, -100, -7, 14, 0, 0};
        vt[5] = '{1, 7, -100, 0, 0, 0};
        vt[6] = '{2, 0, 0, 0, 1, 0};
        vt[7] = '{3, INT_MIN, 1, INT_MIN, 0, 0};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_rsp_dz", 32'(bus.rsp_dz), 0);
        check("rst_rsp_ovf", 32'(bus.rsp_ovf), 0);
        check("rst_div_a", bus.div_a, 0);
        check("rst_div_b", bus.div_b, 0);
        check("rst_inflight", 32'(bus.inflight), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        reset = 1'b1;
        tick();

        // Fairness: all requesters valid for 8 cycles.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NUM_REQ; i++) set_req(i, k * 10 + i * 3 + 1, i - 2);
            #1;
            check("rr_grant", 32'(bus.req_ready), 32'(1) << (k % NUM_REQ));
            tick();
        end
        bus.req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) check("inflight_peak", get_inflight(i), 2);
        wait_drain();
        check("inflight_fair_end", 32'(bus.inflight), 0);

        // Table of single operations.
        for (int v = 0; v < 8; v++) apply_one(vt[v]);

        // r2 issues on relative edges 0, 1 and 5.
        set_req(2, 1000, 3);
        tick();
        check("gap_inflight_e0", get_inflight(2), 1);
        set_req(2, -1000, 7);
        tick();
        check("gap_inflight_e1", get_inflight(2), 2);
        bus.req_valid = '0;
        repeat (3) tick();
        set_req(2, 77, -5);
        tick();
        check("gap_inflight_e5", get_inflight(2), 3);
        bus.req_valid = '0;
        for (int e = 6; e <= 18; e++) begin
            tick();
            if (e == 12) check("gap_inflight_e12", get_inflight(2), 2);
            if (e == 13) check("gap_inflight_e13", get_inflight(2), 1);
            if (e == 17) check("gap_inflight_e17", get_inflight(2), 0);
        end
        wait_drain();

        // Reset while three operations are in flight.
        set_req(3, 50, 5);
        repeat (3) tick();
        bus.req_valid = '0;
        repeat (4) tick();
        reset = 1'b0;
        sbq.delete();
        #1;
        check("midrst_inflight", 32'(bus.inflight), 0);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (20) tick();
        check("midrst_inflight_after", 32'(bus.inflight), 0);
        fresh = '{0, 9, 3, 3, 0, 0};
        apply_one(fresh);

        // r1 issues every cycle for 20 cycles: count settles at the latency.
        for (int k = 0; k < 20; k++) begin
            set_req(1, k * 13 - 50, (k % 5) - 2);
            tick();
            check("stream_inflight", get_inflight(1), (k + 1 < RSP_LAT) ? k + 1 : RSP_LAT);
        end
        bus.req_valid = '0;
        wait_drain();
        check("stream_inflight_end", 32'(bus.inflight), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
